// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//
// Parametrised VGA timing generator with a valid/ready pixel stream input.
// A clock divider produces a pixel tick. Each tick advances the horizontal
// and vertical counters. The sync, colour, display-active and strobe
// outputs are registered on the tick and describe the count that was
// present at that tick.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   enable        1 = timing runs; 0 = divider, counters and outputs freeze
//   si_rgb        stream pixel data (CD bits)
//   si_valid      stream pixel valid
//   si_ready      pixel consumed this cycle (tick inside the active area)
//   hsync         registered horizontal sync
//   vsync         registered vertical sync
//   rgb           registered pixel to the monitor (0 outside the active area)
//   video_on      registered display-active flag
//   hc, vc        current horizontal / vertical counts
//   pix_tick      pixel-advance strobe
//   line_start    one-clock pulse after the tick at hc == 0
//   frame_start   one-clock pulse after the tick at hc == 0, vc == 0
//   underflow     sticky flag: an active pixel arrived without si_valid
//   underflow_clr clears underflow (a new underflow in the same cycle wins)

module vga_sync_gen #(
    parameter int CD           = 12,
    parameter int COUNTER_BITS = 11,
    parameter int CLK_DIV      = 4,
    parameter int HD           = 640,
    parameter int HF           = 16,
    parameter int HR           = 96,
    parameter int HB           = 48,
    parameter int VD           = 480,
    parameter int VF           = 10,
    parameter int VR           = 2,
    parameter int VB           = 33,
    parameter int HSYNC_POL    = 0,
    parameter int VSYNC_POL    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CD-1:0]           si_rgb,
    input  logic                    si_valid,
    output logic                    si_ready,
    output logic                    hsync,
    output logic                    vsync,
    output logic [CD-1:0]           rgb,
    output logic                    video_on,
    output logic [COUNTER_BITS-1:0] hc,
    output logic [COUNTER_BITS-1:0] vc,
    output logic                    pix_tick,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    underflow,
    input  logic                    underflow_clr
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;

    // A single-bit divider register is kept even for CLK_DIV == 1; it then
    // sits at 0, which equals the last divider value, so every enabled
    // clock is a tick.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // All count comparisons happen at counter width.
    localparam logic [COUNTER_BITS-1:0] H_LAST   = COUNTER_BITS'(HT - 1);
    localparam logic [COUNTER_BITS-1:0] V_LAST   = COUNTER_BITS'(VT - 1);
    localparam logic [COUNTER_BITS-1:0] H_DISP   = COUNTER_BITS'(HD);
    localparam logic [COUNTER_BITS-1:0] V_DISP   = COUNTER_BITS'(VD);
    localparam logic [COUNTER_BITS-1:0] HS_FIRST = COUNTER_BITS'(HD + HF);
    localparam logic [COUNTER_BITS-1:0] HS_LAST  = COUNTER_BITS'(HD + HF + HR - 1);
    localparam logic [COUNTER_BITS-1:0] VS_FIRST = COUNTER_BITS'(VD + VF);
    localparam logic [COUNTER_BITS-1:0] VS_LAST  = COUNTER_BITS'(VD + VF + VR - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_ZERO = '0;
    localparam logic [COUNTER_BITS-1:0] CNT_ONE  = COUNTER_BITS'(1);

    localparam logic HS_ON  = 1'(HSYNC_POL);
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_ON  = 1'(VSYNC_POL);
    localparam logic VS_OFF = ~VS_ON;

    localparam bit TIMING_FITS = (longint'(HT) <= (longint'(1) << COUNTER_BITS)) &&
                                 (longint'(VT) <= (longint'(1) << COUNTER_BITS));

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             h_wrap;
    logic             act;
    logic             hs_act;
    logic             vs_act;

    // Tick and decode of the count currently held in hc/vc.
    always_comb begin
        tick   = enable && (div == DIV_LAST);
        h_wrap = (hc == H_LAST);
        act    = (hc < H_DISP) && (vc < V_DISP);
        hs_act = (hc >= HS_FIRST) && (hc <= HS_LAST);
        vs_act = (vc >= VS_FIRST) && (vc <= VS_LAST);
    end

    assign pix_tick = tick;
    assign si_ready = tick && act;

    // Pixel-clock divider. It holds its phase while disabled so that timing
    // resumes exactly where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (enable) begin
            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    // Horizontal and vertical counters; vc advances on the hc wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                hc <= '0;
                if (vc == V_LAST) begin
                    vc <= '0;
                end else begin
                    vc <= vc + CNT_ONE;
                end
            end else begin
                hc <= hc + CNT_ONE;
            end
        end
    end

    // Level outputs describe the count seen at the most recent tick and hold
    // between ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync    <= HS_OFF;
            vsync    <= VS_OFF;
            video_on <= 1'b0;
            rgb      <= '0;
        end else if (tick) begin
            hsync    <= hs_act ? HS_ON : HS_OFF;
            vsync    <= vs_act ? VS_ON : VS_OFF;
            video_on <= act;
            rgb      <= (act && si_valid) ? si_rgb : '0;
        end
    end

    // Strobes are one system clock wide: any clock without a tick (including
    // disabled clocks) drops them, so a pulse is never stretched.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= tick && (hc == CNT_ZERO);
            frame_start <= tick && (hc == CNT_ZERO) && (vc == CNT_ZERO);
        end
    end

    // Sticky underflow. Setting has priority over a simultaneous clear so a
    // fresh underflow is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (tick && act && !si_valid) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

    // Simulation-only guard that the frame fits the counter width.
    always_ff @(posedge clk) begin
        assert (TIMING_FITS);
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//
// Directed bench for vga_sync_gen. Two instances share clock and stimulus:
//   dut_a: tiny timing (HT=8, VT=6), CLK_DIV=1, HSYNC_POL=1
//   dut_b: small timing (HT=24, VT=10), CLK_DIV=4, both polarities 0
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, so each sample shows the registers after that edge.

module tb_vga_sync_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [11:0] si_rgb;
    logic        si_valid;
    logic        underflow_clr;

    logic        a_si_ready, a_hsync, a_vsync, a_video_on, a_pix_tick;
    logic        a_line_start, a_frame_start, a_underflow;
    logic [11:0] a_rgb;
    logic [3:0]  a_hc, a_vc;

    logic        b_si_ready, b_hsync, b_vsync, b_video_on, b_pix_tick;
    logic        b_line_start, b_frame_start, b_underflow;
    logic [11:0] b_rgb;
    logic [10:0] b_hc, b_vc;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .CD(12), .COUNTER_BITS(4), .CLK_DIV(1),
        .HD(4), .HF(1), .HR(2), .HB(1),
        .VD(3), .VF(1), .VR(1), .VB(1),
        .HSYNC_POL(1), .VSYNC_POL(0)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .si_rgb(si_rgb), .si_valid(si_valid), .si_ready(a_si_ready),
        .hsync(a_hsync), .vsync(a_vsync), .rgb(a_rgb), .video_on(a_video_on),
        .hc(a_hc), .vc(a_vc), .pix_tick(a_pix_tick),
        .line_start(a_line_start), .frame_start(a_frame_start),
        .underflow(a_underflow), .underflow_clr(underflow_clr)
    );

    vga_sync_gen #(
        .CD(12), .COUNTER_BITS(11), .CLK_DIV(4),
        .HD(16), .HF(2), .HR(3), .HB(3),
        .VD(6), .VF(1), .VR(2), .VB(1),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .si_rgb(si_rgb), .si_valid(si_valid), .si_ready(b_si_ready),
        .hsync(b_hsync), .vsync(b_vsync), .rgb(b_rgb), .video_on(b_video_on),
        .hc(b_hc), .vc(b_vc), .pix_tick(b_pix_tick),
        .line_start(b_line_start), .frame_start(b_frame_start),
        .underflow(b_underflow), .underflow_clr(underflow_clr)
    );

    // Drive one clock worth of inputs, then step past the next rising edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic valid,
                                 input logic clr, input logic [11:0] pix);
        reset         = rst;
        enable        = en;
        si_valid      = valid;
        underflow_clr = clr;
        si_rgb        = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [11:0] pat;
        logic [11:0] prev_pat;
        int hp, vp;
        bit act_p;
        int n_tick, n_ready, n_ls, n_fs, n_hs_low, n_vs_low, n_von, first_fs;

        // ---------------- reset values ----------------
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("rst_a_hc", 32'(a_hc), 32'd0);
        checkOutput("rst_a_vc", 32'(a_vc), 32'd0);
        checkOutput("rst_a_hsync", 32'(a_hsync), 32'd0);
        checkOutput("rst_a_vsync", 32'(a_vsync), 32'd1);
        checkOutput("rst_a_rgb", 32'(a_rgb), 32'd0);
        checkOutput("rst_a_video_on", 32'(a_video_on), 32'd0);
        checkOutput("rst_b_hsync", 32'(b_hsync), 32'd1);
        checkOutput("rst_b_vsync", 32'(b_vsync), 32'd1);
        checkOutput("rst_b_line_start", 32'(b_line_start), 32'd0);
        checkOutput("rst_b_frame_start", 32'(b_frame_start), 32'd0);
        checkOutput("rst_b_underflow", 32'(b_underflow), 32'd0);

        // ---------------- dut_a: one frame plus, tick every clock ----------------
        for (int k = 1; k <= 60; k++) begin
            pat = 12'(k * 37 + 5);
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, pat);
            hp    = (k - 1) % 8;
            vp    = ((k - 1) / 8) % 6;
            act_p = (hp < 4) && (vp < 3);
            checkOutput("a_hc", 32'(a_hc), 32'(k % 8));
            checkOutput("a_vc", 32'(a_vc), 32'((k / 8) % 6));
            checkOutput("a_video_on", 32'(a_video_on), 32'(act_p));
            checkOutput("a_hsync", 32'(a_hsync), 32'(hp == 5 || hp == 6));
            checkOutput("a_vsync", 32'(a_vsync), 32'(vp != 4));
            checkOutput("a_line_start", 32'(a_line_start), 32'(hp == 0));
            checkOutput("a_frame_start", 32'(a_frame_start), 32'(hp == 0 && vp == 0));
            checkOutput("a_rgb", 32'(a_rgb), act_p ? 32'(pat) : 32'd0);
            checkOutput("a_si_ready", 32'(a_si_ready),
                        32'((k % 8) < 4 && ((k / 8) % 6) < 3));
        end
        checkOutput("a_underflow_idle", 32'(a_underflow), 32'd0);

        // ---------------- dut_b: one full frame of event counts ----------------
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h123);
        n_tick = 0; n_ready = 0; n_ls = 0; n_fs = 0;
        n_hs_low = 0; n_vs_low = 0; n_von = 0; first_fs = 0;
        for (int j = 1; j <= 960; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h123);
            if (b_pix_tick) n_tick++;
            if (b_si_ready) n_ready++;
            if (b_line_start) n_ls++;
            if (b_frame_start) begin
                n_fs++;
                if (first_fs == 0) first_fs = j;
            end
            if (!b_hsync) n_hs_low++;
            if (!b_vsync) n_vs_low++;
            if (b_video_on) n_von++;
            if (j == 67) checkOutput("b_von_before_hd", 32'(b_video_on), 32'd1);
            if (j == 68) checkOutput("b_von_after_hd", 32'(b_video_on), 32'd0);
        end
        checkOutput("b_tick_count", 32'(n_tick), 32'd240);
        checkOutput("b_ready_count", 32'(n_ready), 32'd96);
        checkOutput("b_line_start_count", 32'(n_ls), 32'd10);
        checkOutput("b_frame_start_count", 32'(n_fs), 32'd1);
        checkOutput("b_frame_start_clk", 32'(first_fs), 32'd4);
        checkOutput("b_hsync_low_clks", 32'(n_hs_low), 32'd120);
        checkOutput("b_vsync_low_clks", 32'(n_vs_low), 32'd192);
        checkOutput("b_video_on_clks", 32'(n_von), 32'd384);
        checkOutput("b_hc_wrapped", 32'(b_hc), 32'd0);
        checkOutput("b_vc_wrapped", 32'(b_vc), 32'd0);

        // ---------------- dut_b: underflow set / clear priority ----------------
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'hABC);
        for (int j = 1; j <= 244; j++) begin
            applyStimulus(1'b0, 1'b1, !(j == 236 || j == 240),
                          (j == 238 || j == 240 || j == 241), 12'hABC);
            case (j)
                232: checkOutput("uf_rgb_valid", 32'(b_rgb), 32'hABC);
                235: checkOutput("uf_before", 32'(b_underflow), 32'd0);
                236: begin
                    checkOutput("uf_rgb_dropped", 32'(b_rgb), 32'd0);
                    checkOutput("uf_set", 32'(b_underflow), 32'd1);
                    checkOutput("uf_video_on", 32'(b_video_on), 32'd1);
                end
                237: checkOutput("uf_sticky", 32'(b_underflow), 32'd1);
                238: checkOutput("uf_clear_alone", 32'(b_underflow), 32'd0);
                240: checkOutput("uf_set_wins", 32'(b_underflow), 32'd1);
                241: checkOutput("uf_clear_again", 32'(b_underflow), 32'd0);
                244: checkOutput("uf_stays_clear", 32'(b_underflow), 32'd0);
                default: ;
            endcase
        end

        // ---------------- enable freeze for 50 clocks mid-line ----------------
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h5A5);
        for (int j = 1; j <= 50; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h5A5);
        end
        checkOutput("frz_b_hc_start", 32'(b_hc), 32'd12);
        checkOutput("frz_a_hc_start", 32'(a_hc), 32'd2);
        for (int i = 1; i <= 50; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0);
            checkOutput("frz_b_hc", 32'(b_hc), 32'd12);
            checkOutput("frz_b_vc", 32'(b_vc), 32'd0);
            checkOutput("frz_b_tick", 32'(b_pix_tick), 32'd0);
            checkOutput("frz_b_ready", 32'(b_si_ready), 32'd0);
            checkOutput("frz_b_rgb", 32'(b_rgb), 32'h5A5);
            checkOutput("frz_b_von", 32'(b_video_on), 32'd1);
            checkOutput("frz_a_hc", 32'(a_hc), 32'd2);
            checkOutput("frz_a_rgb", 32'(a_rgb), 32'h5A5);
            checkOutput("frz_a_tick", 32'(a_pix_tick), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h0F0);
        checkOutput("res_b_hc_1", 32'(b_hc), 32'd12);
        checkOutput("res_b_tick_1", 32'(b_pix_tick), 32'd1);
        checkOutput("res_a_hc_1", 32'(a_hc), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h0F0);
        checkOutput("res_b_hc_2", 32'(b_hc), 32'd13);
        checkOutput("res_b_rgb_2", 32'(b_rgb), 32'h0F0);
        checkOutput("res_a_hc_2", 32'(a_hc), 32'd4);

        // ---------------- reset mid-frame inside both sync pulses ----------------
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h777);
        for (int j = 1; j <= 752; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h777);
        end
        checkOutput("mid_b_hc", 32'(b_hc), 32'd20);
        checkOutput("mid_b_hsync", 32'(b_hsync), 32'd0);
        checkOutput("mid_b_vsync", 32'(b_vsync), 32'd0);
        checkOutput("mid_b_underflow", 32'(b_underflow), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h777);
        checkOutput("mrst_b_hc", 32'(b_hc), 32'd0);
        checkOutput("mrst_b_vc", 32'(b_vc), 32'd0);
        checkOutput("mrst_b_hsync", 32'(b_hsync), 32'd1);
        checkOutput("mrst_b_vsync", 32'(b_vsync), 32'd1);
        checkOutput("mrst_b_rgb", 32'(b_rgb), 32'd0);
        checkOutput("mrst_b_von", 32'(b_video_on), 32'd0);
        checkOutput("mrst_b_underflow", 32'(b_underflow), 32'd0);
        prev_pat = 12'h321;
        for (int j = 1; j <= 5; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, prev_pat);
            checkOutput("post_rst_frame_start", 32'(b_frame_start), 32'(j == 4));
            if (j == 4) begin
                checkOutput("post_rst_line_start", 32'(b_line_start), 32'd1);
                checkOutput("post_rst_hc", 32'(b_hc), 32'd1);
                checkOutput("post_rst_rgb", 32'(b_rgb), 32'h321);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Parametrised VGA timing generator with stream pixel input. Successor to the fixed 640x480 sync block.
- Timing, pixel-clock divider, sync polarity and colour depth are all parameters.
- Adds a valid/ready pixel handshake, an enable, frame and line strobes, and sticky underflow detection.
- Sits between the frame-buffer/pixel stream source and the VGA pins.

Parameters:
CD, 12, colour depth in bits of rgb
COUNTER_BITS, 11, width of hc/vc; must hold HT-1 and VT-1
CLK_DIV, 4, system clocks per pixel (>=1); 1 means a tick every clock
HD, 640, horizontal display pixels
HF, 16, horizontal front porch
HR, 96, horizontal retrace (sync pulse)
HB, 48, horizontal back porch
VD, 480, vertical display lines
VF, 10, vertical front porch
VR, 2, vertical retrace
VB, 33, vertical back porch
HSYNC_POL, 0, active level of hsync
VSYNC_POL, 0, active level of vsync

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = timing runs; 0 = freeze divider and counters
si_rgb  in  CD  stream pixel data
si_valid  in  1  stream pixel valid
si_ready  out  1  pixel consumed this cycle
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
rgb  out  CD  registered pixel to monitor
video_on  out  1  registered display-active flag
hc  out  COUNTER_BITS  current horizontal count
vc  out  COUNTER_BITS  current vertical count
pix_tick  out  1  pixel-advance strobe
line_start  out  1  one-clock pulse, registered
frame_start  out  1  one-clock pulse, registered
underflow  out  1  sticky missing-pixel flag
underflow_clr  in  1  clears underflow

Behaviour:
Derived values:
- HT = HD+HF+HR+HB.
- VT = VD+VF+VR+VB.

Divider:
- div counts 0..CLK_DIV-1 while enable=1.
- pix_tick = enable && (div == CLK_DIV-1). When CLK_DIV=1, pix_tick = enable.
- enable=0: div holds its value, no ticks, counters and all registered outputs hold.

Counters:
- hc,vc are the counter registers themselves (no extra delay).
- On pix_tick, hc increments and wraps HT-1 -> 0.
- On the hc wrap, vc increments and wraps VT-1 -> 0.

Combinational decode of the current (hc,vc):
- act = (hc<HD) && (vc<VD).
- hs_act = HD+HF <= hc <= HD+HF+HR-1.
- vs_act = VD+VF <= vc <= VD+VF+VR-1.

Handshake:
- si_ready = pix_tick && act. This is the only cycle a pixel is consumed.
- si_valid has no effect outside si_ready cycles.

Output registers (update only on pix_tick edges; latency = 1 clock after the tick, aligned to the counts present at that tick):
- hsync <= hs_act ? HSYNC_POL : !HSYNC_POL.
- vsync <= vs_act ? VSYNC_POL : !VSYNC_POL.
- video_on <= act.
- rgb <= (act && si_valid) ? si_rgb : 0.
- line_start <= (hc==0), high for one clock only.
- frame_start <= (hc==0 && vc==0), high for one clock only.

Underflow:
- Set when pix_tick && act && !si_valid.
- Cleared by underflow_clr. If set and clear occur in the same cycle, set wins.

Reset values (synchronous reset overrides enable):
- div=0, hc=0, vc=0.
- hsync=!HSYNC_POL, vsync=!VSYNC_POL.
- rgb=0, video_on=0, line_start=0, frame_start=0, underflow=0.
- Reset mid-frame restarts timing at (0,0). The first tick after reset emits frame_start.

Width rule: all compares are done at COUNTER_BITS width. Implementation asserts (simulation only) that HT <= 2**COUNTER_BITS.

Test Plan:
- Defaults, si_valid=1, run 1 frame -> pix_tick every 4th clk.
  - One line = 3200 clk; one frame = 1,680,000 clk.
  - hsync low for hc 656..751 (96 ticks); vsync low for vc 490..491.
  - si_ready count = 307,200.
- Defaults -> frame_start exactly one per frame, 1 clk after the tick at (0,0).
  - 525 line_start pulses per frame.
  - video_on falls 1 clk after the tick at hc=640.
- Small timing (HD=4,HF=1,HR=2,HB=1,VD=3,VF=1,VR=1,VB=1), CLK_DIV=1, HSYNC_POL=1:
  - HT=8, VT=6; tick every clk.
  - hsync high for hc 5..6; rgb follows si_rgb with 1-clk delay in the active area, else 0.
- Drop si_valid at hc=10,vc=2 -> rgb=0 for that pixel, underflow=1 and stays 1.
  - Same-cycle underflow_clr during a new underflow -> remains 1.
  - Clear alone -> 0.
- enable=0 for 50 clk mid-line -> hc,vc,div and outputs frozen; timing resumes from the same count.
- Assert reset at hc=300,vc=200 -> next clk hc=vc=0, hsync=vsync=1 (POL=0), rgb=0, underflow=0.
  - First tick after release yields frame_start.
